// File: rtl/key_debounce_scheduler.sv
// rtl/key_debounce_scheduler.sv - N-key debouncer sharing one settle timer via a round-robin grant
module key_debounce_scheduler #(
    parameter int N_KEYS        = 4,
    parameter int SETTLE_CYCLES = 1000000,
    parameter int CW            = 20,
    parameter int IW            = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              busy,
    output logic [IW-1:0]     active_idx
);

    typedef enum logic [1:0] {IDLE, TIMING, COMMIT} state_t;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW:0]   N_WIDE      = (IW+1)'(N_KEYS);

    state_t              state, state_next;
    logic [N_KEYS-1:0]   sync1, sync2;
    logic [N_KEYS-1:0]   cand, mismatch, rot;
    logic [IW-1:0]       ptr, grant_idx, next_ptr;
    logic [IW:0]         grant_off, grant_sum;
    logic [CW-1:0]       timer;
    logic                grant_found, do_grant, do_abort, do_commit;

    assign cand     = ~sync2;
    assign mismatch = cand ^ key_level;
    assign busy     = (state != IDLE);
    assign next_ptr = (active_idx == IW'(N_KEYS - 1)) ? '0 : active_idx + 1'b1;

    // Rotate so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        rot         = N_KEYS'({mismatch, mismatch} >> ptr);
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_found = 1'b1;
                grant_off   = (IW+1)'(k);
            end
        end
        grant_sum = {1'b0, ptr} + grant_off;
        grant_idx = (grant_sum >= N_WIDE) ? IW'(grant_sum - N_WIDE) : IW'(grant_sum);
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_abort   = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    do_grant   = 1'b1;
                    state_next = TIMING;
                end
            end
            TIMING: begin
                if (!mismatch[active_idx]) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end else if (timer == SETTLE_LAST) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                // A level that slipped back on the final edge is not committed.
                do_commit  = mismatch[active_idx];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '1;
            sync2       <= '1;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            active_idx  <= '0;
            ptr         <= '0;
            timer       <= '0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            key_press   <= '0;
            key_release <= '0;
            if (do_grant) begin
                active_idx <= grant_idx;
                timer      <= '0;
            end else if (state == TIMING && state_next == TIMING) begin
                timer <= timer + 1'b1;
            end
            if (do_abort || state == COMMIT) begin
                ptr <= next_ptr;
            end
            if (do_commit) begin
                key_level[active_idx] <= cand[active_idx];
                if (cand[active_idx]) begin
                    key_press[active_idx] <= 1'b1;
                end else begin
                    key_release[active_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// tb/tb_key_debounce_scheduler.sv - directed and randomized checks against a behavioural model
module tb_key_debounce_scheduler;

    localparam int N      = 4;
    localparam int SETTLE = 8;
    localparam int CW     = 4;
    localparam int IW     = 2;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic [N-1:0]  key_in   = '1;
    logic [N-1:0]  key_level, key_press, key_release;
    logic          busy;
    logic [IW-1:0] active_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    key_debounce_scheduler #(
        .N_KEYS(N), .SETTLE_CYCLES(SETTLE), .CW(CW), .IW(IW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key_in(key_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .busy(busy), .active_idx(active_idx)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: an owner key and its age since grant; commit once the
    // new level has survived SETTLE further edges after the grant.
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, want;
    int m_owner, m_age, m_ptr, m_k;

    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_rel = '0;
            m_owner = -1; m_age = 0; m_ptr = 0;
        end else begin
            want = ~m_s2;
            m_press = '0;
            m_rel   = '0;
            if (m_owner < 0) begin
                for (int d = N - 1; d >= 0; d--) begin
                    m_k = (m_ptr + d) % N;
                    if (want[m_k] != m_level[m_k]) begin
                        m_owner = m_k;
                        m_age   = 0;
                    end
                end
            end else if (want[m_owner] == m_level[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_age == SETTLE) begin
                m_level[m_owner] = want[m_owner];
                if (want[m_owner]) m_press[m_owner] = 1'b1;
                else               m_rel[m_owner]   = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_age++;
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    end

    task automatic tick;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        key_in  = '1;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        tests_run++;
        if ({key_level, key_press, key_release, busy, active_idx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b exp=0", {key_level, key_press, key_release, busy, active_idx});
        end
    endtask

    task automatic test_clean_press;
        do_reset;
        key_in[0] = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick;
            tests_run++;
            if (busy !== (e >= 3 && e <= 11)) begin
                tests_failed++;
                $display("FAIL press_busy e=%0d got=%b exp=%b", e, busy, (e >= 3 && e <= 11));
            end
            tests_run++;
            if (key_level !== ((e >= 12) ? 4'b0001 : 4'b0000) || key_press !== ((e == 12) ? 4'b0001 : 4'b0000)
                || key_release !== 4'b0000) begin
                tests_failed++;
                $display("FAIL press_out e=%0d lvl=%b prs=%b rel=%b", e, key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_clean_release;
        key_in[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick;
            tests_run++;
            if (key_level !== ((e >= 12) ? 4'b0000 : 4'b0001) || key_release !== ((e == 12) ? 4'b0001 : 4'b0000)
                || key_press !== 4'b0000) begin
                tests_failed++;
                $display("FAIL release_out e=%0d lvl=%b prs=%b rel=%b", e, key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_bounce;
        int presses = 0, rels = 0, press_edge = 0, rises = 0;
        logic prev_busy = 1'b0;
        do_reset;
        for (int e = 1; e <= 50; e++) begin
            if (e <= 30) key_in[1] = (((e - 1) / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else         key_in[1] = 1'b0;
            tick;
            if (e <= 30 && busy && !prev_busy) rises++;
            prev_busy = busy;
            if (key_press[1]) begin presses++; press_edge = e; end
            if (key_release != 0) rels++;
        end
        tests_run++;
        if (rises != 5) begin
            tests_failed++;
            $display("FAIL bounce_grants got=%0d exp=5", rises);
        end
        tests_run++;
        if (presses != 1 || rels != 0 || press_edge != 42) begin
            tests_failed++;
            $display("FAIL bounce_press got=%0d@%0d rel=%0d exp=1@42 rel=0", presses, press_edge, rels);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        key_in[0] = 1'b0;
        key_in[2] = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick;
            if (e == 3 || e == 13) begin
                tests_run++;
                if (!busy || active_idx !== ((e == 3) ? 2'd0 : 2'd2)) begin
                    tests_failed++;
                    $display("FAIL b2b_idx e=%0d busy=%b got=%0d", e, busy, active_idx);
                end
            end
            if (e == 12 || e == 22 || e == 23) begin
                tests_run++;
                if (key_press !== ((e == 12) ? 4'b0001 : (e == 22) ? 4'b0100 : 4'b0000)
                    || key_level !== ((e == 12) ? 4'b0001 : 4'b0101)) begin
                    tests_failed++;
                    $display("FAIL b2b_commit e=%0d lvl=%b prs=%b", e, key_level, key_press);
                end
            end
        end
    endtask

    task automatic test_fairness;
        int k3_edge = 0, k0_rel_edge = 0;
        do_reset;
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        for (int e = 1; e <= 36; e++) begin
            tick;
            if (e == 12) begin
                tests_run++;
                if (key_press !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL fair_first got=%b exp=0001", key_press);
                end
                key_in[0] = 1'b1;
            end
            if (key_press[3])   k3_edge     = e;
            if (key_release[0]) k0_rel_edge = e;
        end
        tests_run++;
        if (k3_edge != 22 || k0_rel_edge != 32) begin
            tests_failed++;
            $display("FAIL fair_order key3@%0d key0rel@%0d exp 22 and 32", k3_edge, k0_rel_edge);
        end
    endtask

    task automatic test_reset_mid_timing;
        logic was_busy;
        do_reset;
        key_in[0] = 1'b0;
        for (int e = 1; e <= 6; e++) tick;
        was_busy = busy;
        reset_n  = 1'b0;
        #1;
        tests_run++;
        if (!was_busy || busy !== 1'b0 || {key_level, key_press, key_release} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset was_busy=%b busy=%b outs=%b", was_busy, busy, {key_level, key_press, key_release});
        end
        tick;
        tick;
        reset_n = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick;
            tests_run++;
            if (key_level[0] !== (e >= 12) || key_press[0] !== (e == 12)) begin
                tests_failed++;
                $display("FAIL reset_redebounce e=%0d lvl=%b prs=%b", e, key_level[0], key_press[0]);
            end
        end
    endtask

    task automatic test_random;
        bit noisy;
        do_reset;
        for (int c = 0; c < 4000; c++) begin
            noisy = ((c / 150) % 2) == 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(noisy ? 3 : 90, 0) == 0) key_in[i] = ~key_in[i];
            end
            tick;
            tests_run++;
            if (key_level !== m_level || key_press !== m_press || key_release !== m_rel) begin
                tests_failed++;
                $display("FAIL rand_outs c=%0d lvl=%b/%b prs=%b/%b rel=%b/%b", c,
                         key_level, m_level, key_press, m_press, key_release, m_rel);
            end
            tests_run++;
            if (busy !== (m_owner >= 0) || (m_owner >= 0 && active_idx !== m_owner[IW-1:0])) begin
                tests_failed++;
                $display("FAIL rand_grant c=%0d busy=%b idx=%0d exp_owner=%0d", c, busy, active_idx, m_owner);
            end
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_clean_release;
        test_bounce;
        test_back_to_back;
        test_fairness;
        test_reset_mid_timing;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
